// File: rtl/time_slot_arbiter_if.sv
// time_slot_arbiter_if: bundle of requester, tick and generator-control signals
// shared between the vending logic and time_slot_arbiter.
// The master modport is the requester/generator side; slave is the arbiter.
// wdog_err exists only when TSA_WDOG_EN is defined.
interface time_slot_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] dur;
  logic [N_REQ-1:0]   cancel;
  logic               half_second;
  logic               second;
  logic               three_seconds;
  logic               five_seconds;
  logic               tg_set;
  logic               tg_en;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic               busy;
`ifdef TSA_WDOG_EN
  logic               wdog_err;

  modport master (
    output req, dur, cancel, half_second, second, three_seconds, five_seconds,
    input  tg_set, tg_en, grant, done, busy, wdog_err
  );
  modport slave (
    input  req, dur, cancel, half_second, second, three_seconds, five_seconds,
    output tg_set, tg_en, grant, done, busy, wdog_err
  );
`else
  modport master (
    output req, dur, cancel, half_second, second, three_seconds, five_seconds,
    input  tg_set, tg_en, grant, done, busy
  );
  modport slave (
    input  req, dur, cancel, half_second, second, three_seconds, five_seconds,
    output tg_set, tg_en, grant, done, busy
  );
`endif
endinterface

// File: rtl/time_slot_arbiter.sv
// time_slot_arbiter: round-robin owner of the shared time generator.
// Sequence per grant: IDLE -> ARM (tg_set pulse) -> CLR (generator settles,
// tick history preloaded) -> RUN (tg_en, wait for rising tick edge) -> DONE
// (one-cycle done to owner) -> IDLE. Cancel or a dropped req aborts to IDLE.
// All outputs are decoded from registered state, so they are glitch-free.
// Optional feature macro: TSA_WDOG_EN adds a RUN-time watchdog (WDOG_CYCLES)
// and the sticky wdog_err output.
module time_slot_arbiter #(
  parameter int N_REQ = 3
`ifdef TSA_WDOG_EN
  ,
  parameter int WDOG_CYCLES = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  time_slot_arbiter_if.slave   bus
);

  localparam int OW = $clog2(N_REQ);
  localparam logic [OW:0]   N_L  = (OW+1)'(N_REQ);
  localparam logic [OW-1:0] LAST = OW'(N_REQ - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    CLR  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [OW-1:0] owner_reg, owner_next;
  logic [OW-1:0] ptr_reg, ptr_next;
  logic [1:0]    dur_reg, dur_next;
  logic          tick_reg, tick_next;

  logic [1:0]    dur_arr [N_REQ];
  logic [OW-1:0] pick;
  logic          found;
  logic [OW:0]   cand;
  logic          sel_tick;
  logic          owner_kill;
  logic          owner_active;
  logic [OW-1:0] owner_inc;

`ifdef TSA_WDOG_EN
  logic [31:0]   cnt_reg, cnt_next;
  logic          wdog_reg, wdog_next;
`endif

  genvar gi;

  // Unpack per-requester duration codes and decode one-hot grant/done.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign dur_arr[gi]   = bus.dur[2*gi +: 2];
      assign bus.grant[gi] = owner_active && (owner_reg == OW'(gi));
      assign bus.done[gi]  = (state_reg == DONE) && (owner_reg == OW'(gi));
    end
  endgenerate

  assign owner_active = (state_reg == ARM) || (state_reg == CLR) || (state_reg == RUN);
  assign bus.tg_set   = (state_reg == ARM);
  assign bus.tg_en    = (state_reg == RUN);
  assign bus.busy     = (state_reg != IDLE);
`ifdef TSA_WDOG_EN
  assign bus.wdog_err = wdog_reg;
`endif

  // Dropping req is treated exactly like cancelling.
  assign owner_kill = bus.cancel[owner_reg] | ~bus.req[owner_reg];
  assign owner_inc  = (owner_reg == LAST) ? '0 : owner_reg + 1'b1;

  // Round-robin pick: first requester at or after the pointer, wrapping to 0.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_reg} + (OW+1)'(k);
      if (cand >= N_L) cand = cand - N_L;
      if (!found && bus.req[cand[OW-1:0]]) begin
        found = 1'b1;
        pick  = cand[OW-1:0];
      end
    end
  end

  // Select the tick matching the duration latched at grant time.
  always_comb begin
    sel_tick = bus.half_second;
    case (dur_reg)
      2'd0: sel_tick = bus.half_second;
      2'd1: sel_tick = bus.second;
      2'd2: sel_tick = bus.three_seconds;
      2'd3: sel_tick = bus.five_seconds;
      default: sel_tick = bus.half_second;
    endcase
  end

  // Next-state logic for the sequencer and its bookkeeping registers.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    dur_next   = dur_reg;
    tick_next  = tick_reg;
`ifdef TSA_WDOG_EN
    cnt_next   = cnt_reg;
    wdog_next  = wdog_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (found) begin
          owner_next = pick;
          dur_next   = dur_arr[pick];
          state_next = ARM;
        end
      end
      ARM: begin
        if (owner_kill) begin
          ptr_next   = owner_inc;
          state_next = IDLE;
        end else begin
          state_next = CLR;
        end
      end
      CLR: begin
        if (owner_kill) begin
          ptr_next   = owner_inc;
          state_next = IDLE;
        end else begin
          // Preload history so a tick already high is not seen as an edge.
          tick_next  = sel_tick;
`ifdef TSA_WDOG_EN
          cnt_next   = '0;
`endif
          state_next = RUN;
        end
      end
      RUN: begin
        tick_next = sel_tick;
`ifdef TSA_WDOG_EN
        cnt_next  = cnt_reg + 32'd1;
`endif
        if (owner_kill) begin
          // Cancel beats a coincident tick edge.
          ptr_next   = owner_inc;
          state_next = IDLE;
        end else if (sel_tick && !tick_reg) begin
          state_next = DONE;
        end
`ifdef TSA_WDOG_EN
        else if (cnt_reg == 32'(WDOG_CYCLES - 1)) begin
          wdog_next  = 1'b1;
          state_next = DONE;
        end
`endif
      end
      DONE: begin
        ptr_next   = owner_inc;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and bookkeeping registers; reset leaves the generator disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      ptr_reg   <= '0;
      dur_reg   <= '0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      dur_reg   <= dur_next;
      tick_reg  <= tick_next;
    end
  end

`ifdef TSA_WDOG_EN
  // Watchdog cycle counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      wdog_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      wdog_reg <= wdog_next;
    end
  end
`endif

endmodule
